// File: rtl/contador_regressivo_mmss_pkg.sv
// contador_regressivo_mmss_pkg: shared FSM encoding, BCD limits and load clamps for the MM:SS countdown timer
// Contents:
//   state_t          IDLE/RUN/PAUSE/DONE, 2-bit encoding
//   MAX_UNIT         largest BCD units/minutes-tens digit (9)
//   MAX_SEC_TENS     largest seconds-tens digit (5)
//   clamp_unit()     saturate a 4-bit load digit to MAX_UNIT
//   clamp_sec_tens() saturate a 3-bit load digit to MAX_SEC_TENS
package contador_regressivo_mmss_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam logic [3:0] MAX_UNIT     = 4'd9;
    localparam logic [2:0] MAX_SEC_TENS = 3'd5;
    function automatic logic [3:0] clamp_unit(input logic [3:0] v);
        return (v > MAX_UNIT) ? MAX_UNIT : v;
    endfunction
    function automatic logic [2:0] clamp_sec_tens(input logic [2:0] v);
        return (v > MAX_SEC_TENS) ? MAX_SEC_TENS : v;
    endfunction
endpackage

// File: rtl/contador_regressivo_mmss_digito.sv
// digito_regressivo: one loadable down-counting digit that wraps 0 -> MAX and borrows from the next digit
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset, clears q
//   en         in  decrement request (borrow from the lower digit or the 1 s tick)
//   load       in  capture ld_val, overrides en
//   ld_val     in  value to load (already clamped by the parent)
//   q          out current digit value
//   borrow_out out high when this digit wraps, i.e. en while q == 0
module digito_regressivo
    import contador_regressivo_mmss_pkg::*;
#(
    parameter int             W   = 4,
    parameter logic [W-1:0]   MAX = W'(MAX_UNIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         borrow_out
);
    assign borrow_out = en && (q == '0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (load)
            q <= ld_val;
        else if (en)
            q <= (q == '0) ? MAX : q - W'(1);
    end
endmodule

// File: rtl/contador_regressivo_mmss.sv
// contador_regressivo_mmss: loadable BCD MM:SS countdown timer with start/pause control and a completion pulse
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-low reset
//   load        in  1-cycle pulse, captures ld_* (clamped) and returns to IDLE
//   ld_min_d    in  minutes tens to load
//   ld_min_u    in  minutes units to load
//   ld_sec_d    in  seconds tens to load
//   ld_sec_u    in  seconds units to load
//   start_stop  in  1-cycle pulse, start/pause toggle
//   min_d..sec_u out current count digits
//   running     out high while counting
//   done_pulse  out one-cycle pulse after the count reaches 00:00
module contador_regressivo_mmss
    import contador_regressivo_mmss_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_min_d,
    input  logic [3:0] ld_min_u,
    input  logic [2:0] ld_sec_d,
    input  logic [3:0] ld_sec_u,
    input  logic       start_stop,
    output logic [3:0] min_d,
    output logic [3:0] min_u,
    output logic [2:0] sec_d,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done_pulse
);
    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_done;
    logic          w_tick, w_zero, w_last, w_fin;
    logic          w_b_su, w_b_sd, w_b_mu, w_b_md;
    logic [3:0]    w_ld_min_d, w_ld_min_u, w_ld_sec_u;
    logic [2:0]    w_ld_sec_d;
    assign w_ld_min_d = clamp_unit(ld_min_d);
    assign w_ld_min_u = clamp_unit(ld_min_u);
    assign w_ld_sec_d = clamp_sec_tens(ld_sec_d);
    assign w_ld_sec_u = clamp_unit(ld_sec_u);
    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
    assign w_zero = {min_d, min_u, sec_d, sec_u} == 15'd0;
    assign w_last = {min_d, min_u, sec_d, sec_u} == 15'd1;
    // The borrow out of the minutes tens would mean a tick at 00:00; it also ends the run so the count can never wrap.
    assign w_fin  = w_tick && (w_last || w_b_md);
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_stop && !w_zero) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = w_fin ? ST_DONE : (start_stop ? ST_PAUSE : ST_RUN);
            ST_PAUSE: if (start_stop) w_state_nxt = ST_RUN;
            ST_DONE:  if (start_stop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (load)
            w_state_nxt = ST_IDLE;
    end
    // The pausing edge freezes the prescaler so a resume continues the interrupted second exactly where it left off.
    assign w_presc_nxt = load                  ? '0 :
                         (r_state == ST_RUN)   ? (w_tick ? '0 : (start_stop ? r_presc : r_presc + PW'(1))) :
                         (r_state == ST_PAUSE) ? r_presc : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_fin && !load;
        end
    end
    digito_regressivo #(.W(4), .MAX(MAX_UNIT)) u_sec_u (
        .clk(clk), .rst(rst), .en(w_tick), .load(load), .ld_val(w_ld_sec_u), .q(sec_u), .borrow_out(w_b_su)
    );
    digito_regressivo #(.W(3), .MAX(MAX_SEC_TENS)) u_sec_d (
        .clk(clk), .rst(rst), .en(w_b_su), .load(load), .ld_val(w_ld_sec_d), .q(sec_d), .borrow_out(w_b_sd)
    );
    digito_regressivo #(.W(4), .MAX(MAX_UNIT)) u_min_u (
        .clk(clk), .rst(rst), .en(w_b_sd), .load(load), .ld_val(w_ld_min_u), .q(min_u), .borrow_out(w_b_mu)
    );
    digito_regressivo #(.W(4), .MAX(MAX_UNIT)) u_min_d (
        .clk(clk), .rst(rst), .en(w_b_mu), .load(load), .ld_val(w_ld_min_d), .q(min_d), .borrow_out(w_b_md)
    );
    assign running    = (r_state == ST_RUN);
    assign done_pulse = r_done;
endmodule
